// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, I-cache request, IF/ID register,
// buffering of redirects that arrive while the pipeline is frozen, and perf counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_icache_stall,
  input  logic        i_dcache_stall,
  input  logic        i_hold,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic [31:0] i_icache_rdata,
  output logic        o_icache_ren,
  output logic [31:0] o_icache_addr,
  output logic        o_ifid_valid,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc4,
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_stall_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  logic        w_freeze;
  logic        w_advance;
  logic        w_pend_valid;
  logic        w_take;
  logic [31:0] w_target;
  logic [31:0] w_pc4;
  logic [31:0] w_pend_pc_nxt;

  // Pending-redirect register: RUN/PEND state plus its buffered target
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_RUN;
      r_pend_pc <= 32'h0000_0000;
    end else begin
      r_state   <= w_state_nxt;
      r_pend_pc <= w_pend_pc_nxt;
    end
  end

  // Next-state logic; a fresh redirect takes priority over the buffered one
  always_comb begin
    w_state_nxt   = r_state;
    w_pend_pc_nxt = r_pend_pc;
    w_freeze      = i_icache_stall | i_dcache_stall | i_hold;
    w_advance     = ~w_freeze;
    w_pend_valid  = (r_state == ST_PEND);
    w_take        = i_redirect | w_pend_valid;
    w_target      = i_redirect ? i_redirect_pc : r_pend_pc;
    w_pc4         = r_pc + 32'd4;
    if (w_freeze && i_redirect) begin
      w_pend_pc_nxt = i_redirect_pc;
    end else begin
      w_pend_pc_nxt = r_pend_pc;
    end
    case (r_state)
      ST_RUN: begin
        if (w_freeze && i_redirect) begin
          w_state_nxt = ST_PEND;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_PEND: begin
        if (w_advance) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_PEND;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // PC, IF/ID register and counters; a taken redirect inserts one bubble
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc          <= RESET_PC;
      r_ifid_valid  <= 1'b0;
      r_ifid_instr  <= 32'h0000_0000;
      r_ifid_pc4    <= 32'h0000_0000;
      r_fetch_count <= 32'h0000_0000;
      r_stall_count <= 32'h0000_0000;
    end else if (w_freeze) begin
      r_stall_count <= r_stall_count + 32'd1;
    end else if (w_take) begin
      r_pc         <= w_target;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= 32'h0000_0000;
      r_ifid_pc4   <= 32'h0000_0000;
    end else begin
      r_pc          <= w_pc4;
      r_ifid_valid  <= 1'b1;
      r_ifid_instr  <= i_icache_rdata;
      r_ifid_pc4    <= w_pc4;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_icache_ren  = ~i_rst;
  assign o_icache_addr = r_pc;
  assign o_ifid_valid  = r_ifid_valid;
  assign o_ifid_instr  = r_ifid_instr;
  assign o_ifid_pc4    = r_ifid_pc4;
  assign o_fetch_count = r_fetch_count;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; I-memory returns {16'hC0DE, addr[15:0]} unless overridden.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        icache_stall;
  logic        dcache_stall;
  logic        hold;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] icache_rdata;
  logic        icache_ren;
  logic [31:0] icache_addr;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  logic        mem_ovr;
  logic [31:0] mem_ovr_word;
  int          n_checks;
  int          n_errors;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_icache_stall (icache_stall),
    .i_dcache_stall (dcache_stall),
    .i_hold         (hold),
    .i_redirect     (redirect),
    .i_redirect_pc  (redirect_pc),
    .i_icache_rdata (icache_rdata),
    .o_icache_ren   (icache_ren),
    .o_icache_addr  (icache_addr),
    .o_ifid_valid   (ifid_valid),
    .o_ifid_instr   (ifid_instr),
    .o_ifid_pc4     (ifid_pc4),
    .o_fetch_count  (fetch_count),
    .o_stall_count  (stall_count)
  );

  assign icache_rdata = mem_ovr ? mem_ovr_word : {16'hC0DE, icache_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    icache_stall = 1'b0; dcache_stall = 1'b0; hold = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; mem_ovr = 1'b0; mem_ovr_word = 32'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++;
    if (icache_ren !== 1'b0 || icache_addr !== 32'h0 || ifid_valid !== 1'b0 ||
        ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0 || fetch_count !== 32'h0 || stall_count !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_state got ren=%b addr=%h v=%b instr=%h pc4=%h fc=%0d sc=%0d exp all zero",
               icache_ren, icache_addr, ifid_valid, ifid_instr, ifid_pc4, fetch_count, stall_count);
    end
    do_reset();
    #1;
    n_checks++;
    if (icache_ren !== 1'b1) begin
      n_errors++; $display("FAIL ren_after_reset got %b exp 1", icache_ren);
    end
  endtask

  task automatic test_fetch();
    do_reset();
    step();
    n_checks++;
    if (icache_addr !== 32'h4 || ifid_instr !== 32'hC0DE_0000 || ifid_pc4 !== 32'h4 || ifid_valid !== 1'b1) begin
      n_errors++; $display("FAIL fetch_A got addr=%h instr=%h pc4=%h v=%b exp 4/C0DE0000/4/1", icache_addr, ifid_instr, ifid_pc4, ifid_valid);
    end
    step();
    n_checks++;
    if (icache_addr !== 32'h8 || ifid_instr !== 32'hC0DE_0004 || ifid_pc4 !== 32'h8) begin
      n_errors++; $display("FAIL fetch_B got addr=%h instr=%h pc4=%h exp 8/C0DE0004/8", icache_addr, ifid_instr, ifid_pc4);
    end
    step();
    n_checks++;
    if (icache_addr !== 32'hC || ifid_instr !== 32'hC0DE_0008 || ifid_pc4 !== 32'hC) begin
      n_errors++; $display("FAIL fetch_C got addr=%h instr=%h pc4=%h exp C/C0DE0008/C", icache_addr, ifid_instr, ifid_pc4);
    end
    step();
    n_checks++;
    if (icache_addr !== 32'h10 || ifid_instr !== 32'hC0DE_000C || fetch_count !== 32'd4 || stall_count !== 32'd0) begin
      n_errors++; $display("FAIL fetch_D got addr=%h instr=%h fc=%0d sc=%0d exp 10/C0DE000C/4/0", icache_addr, ifid_instr, fetch_count, stall_count);
    end
  endtask

  task automatic test_icache_stall();
    do_reset();
    step(); step();
    icache_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (icache_addr !== 32'h8 || ifid_instr !== 32'hC0DE_0004 || ifid_pc4 !== 32'h8 || ifid_valid !== 1'b1) begin
        n_errors++; $display("FAIL istall_hold%0d got addr=%h instr=%h pc4=%h exp 8/C0DE0004/8", i, icache_addr, ifid_instr, ifid_pc4);
      end
    end
    n_checks++;
    if (stall_count !== 32'd3 || fetch_count !== 32'd2) begin
      n_errors++; $display("FAIL istall_counts got sc=%0d fc=%0d exp 3/2", stall_count, fetch_count);
    end
    icache_stall = 1'b0;
    step();
    n_checks++;
    if (icache_addr !== 32'hC || ifid_instr !== 32'hC0DE_0008 || ifid_pc4 !== 32'hC || fetch_count !== 32'd3) begin
      n_errors++; $display("FAIL istall_release got addr=%h instr=%h pc4=%h fc=%0d exp C/C0DE0008/C/3", icache_addr, ifid_instr, ifid_pc4, fetch_count);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    n_checks++;
    if (icache_addr !== 32'h40 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0 || fetch_count !== 32'd4) begin
      n_errors++; $display("FAIL redir_bubble got addr=%h v=%b instr=%h pc4=%h fc=%0d exp 40/0/0/0/4", icache_addr, ifid_valid, ifid_instr, ifid_pc4, fetch_count);
    end
    step();
    n_checks++;
    if (icache_addr !== 32'h44 || ifid_valid !== 1'b1 || ifid_instr !== 32'hC0DE_0040 || ifid_pc4 !== 32'h44 || fetch_count !== 32'd5) begin
      n_errors++; $display("FAIL redir_target got addr=%h v=%b instr=%h pc4=%h fc=%0d exp 44/1/C0DE0040/44/5", icache_addr, ifid_valid, ifid_instr, ifid_pc4, fetch_count);
    end
  endtask

  task automatic test_dcache_pending();
    do_reset();
    step();
    dcache_stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    step();
    n_checks++;
    if (icache_addr !== 32'h4 || ifid_instr !== 32'hC0DE_0000 || ifid_valid !== 1'b1 || stall_count !== 32'd1) begin
      n_errors++; $display("FAIL dstall_c1 got addr=%h instr=%h v=%b sc=%0d exp 4/C0DE0000/1/1", icache_addr, ifid_instr, ifid_valid, stall_count);
    end
    redirect_pc = 32'h90;
    step();
    n_checks++;
    if (dut.r_pend_pc !== 32'h90 || dut.r_state !== 1'b1 || icache_addr !== 32'h4 || stall_count !== 32'd2) begin
      n_errors++; $display("FAIL dstall_pend got pend_pc=%h pend=%b addr=%h sc=%0d exp 90/1/4/2", dut.r_pend_pc, dut.r_state, icache_addr, stall_count);
    end
    dcache_stall = 1'b0; redirect = 1'b0;
    step();
    n_checks++;
    if (icache_addr !== 32'h90 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || fetch_count !== 32'd1 || dut.r_state !== 1'b0) begin
      n_errors++; $display("FAIL dstall_bubble got addr=%h v=%b instr=%h fc=%0d pend=%b exp 90/0/0/1/0", icache_addr, ifid_valid, ifid_instr, fetch_count, dut.r_state);
    end
    step();
    n_checks++;
    if (icache_addr !== 32'h94 || ifid_instr !== 32'hC0DE_0090 || ifid_pc4 !== 32'h94 || ifid_valid !== 1'b1) begin
      n_errors++; $display("FAIL dstall_target got addr=%h instr=%h pc4=%h v=%b exp 94/C0DE0090/94/1", icache_addr, ifid_instr, ifid_pc4, ifid_valid);
    end
  endtask

  task automatic test_hold();
    do_reset();
    step();
    hold = 1'b1; mem_ovr = 1'b1; mem_ovr_word = 32'h8C08_0004;
    step();
    n_checks++;
    if (icache_addr !== 32'h4 || ifid_instr !== 32'hC0DE_0000 || fetch_count !== 32'd1 || stall_count !== 32'd1) begin
      n_errors++; $display("FAIL hold_frozen got addr=%h instr=%h fc=%0d sc=%0d exp 4/C0DE0000/1/1", icache_addr, ifid_instr, fetch_count, stall_count);
    end
    hold = 1'b0;
    step();
    mem_ovr = 1'b0;
    n_checks++;
    if (icache_addr !== 32'h8 || ifid_instr !== 32'h8C08_0004 || ifid_pc4 !== 32'h8 || fetch_count !== 32'd2) begin
      n_errors++; $display("FAIL hold_release got addr=%h instr=%h pc4=%h fc=%0d exp 8/8C080004/8/2", icache_addr, ifid_instr, ifid_pc4, fetch_count);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    n_checks++;
    if (icache_addr !== 32'hFFFF_FFFC || ifid_valid !== 1'b0) begin
      n_errors++; $display("FAIL wrap_target got addr=%h v=%b exp FFFFFFFC/0", icache_addr, ifid_valid);
    end
    step();
    n_checks++;
    if (icache_addr !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_instr !== 32'hC0DE_FFFC || ifid_valid !== 1'b1) begin
      n_errors++; $display("FAIL wrap_pc got addr=%h pc4=%h instr=%h v=%b exp 0/0/C0DEFFFC/1", icache_addr, ifid_pc4, ifid_instr, ifid_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    dcache_stall = 1'b1; redirect_pc = 32'h300;
    step();
    n_checks++;
    if (icache_addr !== 32'h200 || dut.r_state !== 1'b1) begin
      n_errors++; $display("FAIL areset_setup got addr=%h pend=%b exp 200/1", icache_addr, dut.r_state);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (icache_ren !== 1'b0 || icache_addr !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 ||
        ifid_pc4 !== 32'h0 || fetch_count !== 32'h0 || stall_count !== 32'h0 || dut.r_state !== 1'b0) begin
      n_errors++; $display("FAIL areset_immediate got ren=%b addr=%h v=%b instr=%h pc4=%h fc=%0d sc=%0d pend=%b exp 0s",
                           icache_ren, icache_addr, ifid_valid, ifid_instr, ifid_pc4, fetch_count, stall_count, dut.r_state);
    end
    dcache_stall = 1'b0; redirect = 1'b0;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (icache_addr !== 32'h4 || ifid_instr !== 32'hC0DE_0000 || ifid_valid !== 1'b1) begin
      n_errors++; $display("FAIL areset_resume got addr=%h instr=%h v=%b exp 4/C0DE0000/1", icache_addr, ifid_instr, ifid_valid);
    end
    step();
    n_checks++;
    if (icache_addr !== 32'h8 || ifid_instr !== 32'hC0DE_0004 || fetch_count !== 32'd2) begin
      n_errors++; $display("FAIL areset_no_pend got addr=%h instr=%h fc=%0d exp 8/C0DE0004/2", icache_addr, ifid_instr, fetch_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    icache_stall = 1'b0; dcache_stall = 1'b0; hold = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; mem_ovr = 1'b0; mem_ovr_word = 32'h0;
    test_reset();
    test_fetch();
    test_icache_stall();
    test_redirect();
    test_dcache_pending();
    test_hold();
    test_pc_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
